iir_coef_sched: RTL and testbench
=================================

Name: iir_coef_sched

Overview:
Coefficient controller for the N_order IIR filter datapath. Holds a shadow coefficient bank that host logic writes one word at a time. On a commit it checks the unity-DC-gain rule, then swaps the shadow bank into the active bank only at a sample boundary. After the swap it optionally flushes the filter state. The packed active bank drives the filter's i_factor_a / i_factor_b directly.

Parameters:
N_order, 4, number of a and b coefficients each
Width, 16, coefficient width (unsigned)
UNITY, 32768, required sum of all a plus all b coefficients
CHECK_UNITY, 1, 1 = reject commits whose sum is not UNITY
RST_A0, 30000, reset value of a0 (active and shadow banks)
FLUSH_CYC, 4, cycles o_filter_rstn is held low after a swap (0 = no flush)
RAMP_STEP, 1000, per-sample maximum coefficient change (COEF_RAMP_EN only)

Ports:
i_clkp  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_wr_vld  in  1  shadow write request
o_wr_rdy  out  1  shadow write accepted when i_wr_vld & o_wr_rdy
i_wr_sel  in  1  0 = a bank, 1 = b bank
i_wr_idx  in  $clog2(N_order)  coefficient index (0 = a0/b0)
i_wr_data  in  Width  coefficient value
i_commit  in  1  single-cycle commit request
i_smp_stb  in  1  one-cycle strobe marking a filter sample boundary
o_factor_a  out  Width*N_order  active a bank, packed {a[N-1],...,a0}
o_factor_b  out  Width*N_order  active b bank, packed {b[N-1],...,b0}
o_filter_rstn  out  1  active-low reset to the filter (flush)
o_busy  out  1  high in any state other than IDLE
o_swap_done  out  1  one-cycle pulse when the new bank is fully applied
o_gain_err  out  1  sticky: last commit was rejected
o_swap_cnt  out  16  count of completed swaps, wraps at 65535 -> 0

Behaviour:
- Reset values (asynchronous, i_rst high):
  - Both banks: a0 = RST_A0, b0 = UNITY - RST_A0 (2768), all other coefficients 0.
  - State IDLE; o_wr_rdy = 1; o_filter_rstn = 1.
  - o_busy, o_swap_done and o_gain_err = 0; o_swap_cnt = 0.
- State machine: IDLE -> CHECK -> ARMED -> SWAP -> FLUSH -> IDLE.
- IDLE:
  - o_wr_rdy = 1; an accepted write updates the shadow entry on the next edge.
  - i_commit -> CHECK. A write accepted in the same cycle as the commit lands first and is included in the check.
- CHECK (1 cycle):
  - o_wr_rdy = 0.
  - Sum all 2*N_order shadow words into a Width+$clog2(2*N_order) accumulator; the sum never wraps.
  - If CHECK_UNITY and sum != UNITY: set o_gain_err, leave the active bank untouched, -> IDLE.
  - Otherwise clear o_gain_err and -> ARMED.
- ARMED: wait for i_smp_stb. An i_smp_stb in the same cycle as the CHECK->ARMED transition is not used; the block waits for the next strobe. i_commit is ignored.
- SWAP (1 cycle): active bank <= shadow bank, visible on o_factor_* the cycle after the SWAP state. -> FLUSH if FLUSH_CYC > 0, else -> IDLE.
- FLUSH: o_filter_rstn = 0 for exactly FLUSH_CYC cycles, then 1, then -> IDLE.
- o_swap_done pulses, and o_swap_cnt increments, on the transition back to IDLE after a swap.
- In all states except IDLE: o_wr_rdy = 0 and i_commit is ignored (not queued).
- Reset mid-operation: every register returns to its reset value immediately; any pending commit is lost and the shadow bank reverts.
- o_factor_* never change except in SWAP (or RAMP) or on reset.

Optional Feature:
COEF_RAMP_EN
- Defined: SWAP is replaced by RAMP. On each i_smp_stb, every active coefficient moves toward its shadow value by min(|diff|, RAMP_STEP), unsigned arithmetic. When all entries are equal, -> IDLE directly: FLUSH is skipped and o_filter_rstn stays 1.
- Undefined: atomic swap plus FLUSH as described above.

Decomposition:
- Shared package iir_pkg:
  - WIDTH and N_ORDER defaults, UNITY constant.
  - State enum {IDLE, CHECK, ARMED, SWAP, FLUSH, RAMP}.
  - Coefficient word typedef.
- One natural sub-module, iir_coef_bank: a dual-bank register file with write port, swap/ramp-step input and packed outputs. The FSM stays in iir_coef_sched.

Test Plan:
1. Reset -> o_factor_a = {0,0,0,30000}, o_factor_b = {0,0,0,2768}, o_filter_rstn = 1, o_swap_cnt = 0.
2. Write a0 = 20000, b0 = 12768, commit, strobe 5 cycles later -> o_factor_* update exactly one cycle after SWAP; o_filter_rstn low for 4 cycles; o_swap_done pulses once; o_swap_cnt = 1.
3. Write a0 = 20000 only (sum 22768), commit -> o_gain_err = 1, banks unchanged, o_busy back to 0 after 2 cycles.
4. i_wr_vld held high in ARMED -> o_wr_rdy = 0, shadow unchanged; second i_commit ignored; one swap only.
5. Assert i_rst during FLUSH -> o_filter_rstn = 1 and the active bank returns to its reset values immediately, asynchronously.
6. With COEF_RAMP_EN, a0 30000 -> 27000, b0 2768 -> 5768: three strobes move a0 through 29000, 28000, 27000 -> o_swap_done on the third strobe, no flush.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR coefficient controller: default geometry,
// unity-gain constant, FSM state encoding and the coefficient word type.
package iir_pkg;

  localparam int WIDTH   = 16;
  localparam int N_ORDER = 4;
  localparam int UNITY   = 32768;

  typedef enum logic [2:0] {IDLE, CHECK, ARMED, SWAP, FLUSH, RAMP} state_t;

  typedef logic [WIDTH-1:0] coef_t;

endpackage

// File: rtl/iir_coef_bank.sv
// Dual-bank coefficient register file: host-written shadow bank, active bank driving
// the filter, and the shadow sum for the gain check. Define COEF_RAMP_EN for ramped updates.
module iir_coef_bank
  import iir_pkg::*;
#(
  parameter int  N_order   = N_ORDER,
  parameter int  Width     = WIDTH,
  parameter int  UNITY     = iir_pkg::UNITY,
  parameter int  RST_A0    = 30000,
  parameter int  RAMP_STEP = 1000,
  localparam int IDX_W     = $clog2(N_order),
  localparam int SUM_W     = Width + $clog2(2*N_order)
) (
  input  logic                     i_clkp,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic                     i_wr_sel,
  input  logic [IDX_W-1:0]         i_wr_idx,
  input  logic [Width-1:0]         i_wr_data,
  input  logic                     i_step,
  output logic [Width*N_order-1:0] o_factor_a,
  output logic [Width*N_order-1:0] o_factor_b,
  output logic [SUM_W-1:0]         o_shadow_sum
`ifdef COEF_RAMP_EN
  ,
  output logic                     o_ramp_last
`endif
);

  localparam logic [Width-1:0] RST_A = Width'(RST_A0);
  localparam logic [Width-1:0] RST_B = Width'(UNITY - RST_A0);

  logic [Width-1:0] sh_a  [N_order];
  logic [Width-1:0] sh_b  [N_order];
  logic [Width-1:0] act_a [N_order];
  logic [Width-1:0] act_b [N_order];

`ifdef COEF_RAMP_EN
  localparam logic [Width-1:0] STEP = Width'(RAMP_STEP);

  // Move cur toward tgt by at most STEP; never overshoots, so no wrap is possible.
  function automatic logic [Width-1:0] ramp_to(input logic [Width-1:0] cur,
                                               input logic [Width-1:0] tgt);
    logic [Width-1:0] diff;
    diff = (cur < tgt) ? tgt - cur : cur - tgt;
    if (diff <= STEP) return tgt;
    return (cur < tgt) ? cur + STEP : cur - STEP;
  endfunction

  logic [Width-1:0] nxt_a [N_order];
  logic [Width-1:0] nxt_b [N_order];

  always_comb begin
    o_ramp_last = 1'b1;
    for (int i = 0; i < N_order; i++) begin
      nxt_a[i] = ramp_to(act_a[i], sh_a[i]);
      nxt_b[i] = ramp_to(act_b[i], sh_b[i]);
      if (nxt_a[i] != sh_a[i] || nxt_b[i] != sh_b[i]) o_ramp_last = 1'b0;
    end
  end
`endif

  always_ff @(posedge i_clkp or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: both banks are flops rather than RAM, so every entry has a reset value;
      // a reset mid-commit therefore reverts the shadow bank as well as the active one.
      for (int i = 0; i < N_order; i++) begin
        sh_a[i]  <= (i == 0) ? RST_A : '0;
        sh_b[i]  <= (i == 0) ? RST_B : '0;
        act_a[i] <= (i == 0) ? RST_A : '0;
        act_b[i] <= (i == 0) ? RST_B : '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register update order-independent.
      if (i_wr_en) begin
        if (i_wr_sel) sh_b[i_wr_idx] <= i_wr_data;
        else          sh_a[i_wr_idx] <= i_wr_data;
      end
      if (i_step) begin
`ifdef COEF_RAMP_EN
        act_a <= nxt_a;
        act_b <= nxt_b;
`else
        act_a <= sh_a;
        act_b <= sh_b;
`endif
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    o_shadow_sum = '0;
    o_factor_a   = '0;
    o_factor_b   = '0;
    for (int i = 0; i < N_order; i++) begin
      o_shadow_sum = o_shadow_sum + SUM_W'(sh_a[i]) + SUM_W'(sh_b[i]);
      o_factor_a[i*Width +: Width] = act_a[i];
      o_factor_b[i*Width +: Width] = act_b[i];
    end
  end

endmodule

// File: rtl/iir_coef_sched.sv
// Coefficient scheduler FSM: gain-checked commit, swap at a sample boundary, then flush.
// Define COEF_RAMP_EN to replace the atomic swap + flush by a per-sample ramp.
module iir_coef_sched
  import iir_pkg::*;
#(
  parameter int  N_order     = N_ORDER,
  parameter int  Width       = WIDTH,
  parameter int  UNITY       = iir_pkg::UNITY,
  parameter int  CHECK_UNITY = 1,
  parameter int  RST_A0      = 30000,
  parameter int  FLUSH_CYC   = 4,
  parameter int  RAMP_STEP   = 1000,
  localparam int IDX_W       = $clog2(N_order),
  localparam int SUM_W       = Width + $clog2(2*N_order)
) (
  input  logic                     i_clkp,
  input  logic                     i_rst,
  input  logic                     i_wr_vld,
  output logic                     o_wr_rdy,
  input  logic                     i_wr_sel,
  input  logic [IDX_W-1:0]         i_wr_idx,
  input  logic [Width-1:0]         i_wr_data,
  input  logic                     i_commit,
  input  logic                     i_smp_stb,
  output logic [Width*N_order-1:0] o_factor_a,
  output logic [Width*N_order-1:0] o_factor_b,
  output logic                     o_filter_rstn,
  output logic                     o_busy,
  output logic                     o_swap_done,
  output logic                     o_gain_err,
  output logic [15:0]              o_swap_cnt
);

  localparam int               CNT_W     = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [SUM_W-1:0] UNITY_SUM = SUM_W'(UNITY);

  state_t           state;
  logic [CNT_W-1:0] flush_cnt;
  logic [SUM_W-1:0] shadow_sum;
  logic             wr_en;
  logic             bank_step;

  assign wr_en = i_wr_vld && o_wr_rdy;

`ifdef COEF_RAMP_EN
  logic ramp_last;
  assign bank_step = (state == RAMP) && i_smp_stb;
`else
  assign bank_step = (state == SWAP);
`endif

  iir_coef_bank #(
    .N_order   (N_order),
    .Width     (Width),
    .UNITY     (UNITY),
    .RST_A0    (RST_A0),
    .RAMP_STEP (RAMP_STEP)
  ) u_bank (
    .i_clkp       (i_clkp),
    .i_rst        (i_rst),
    .i_wr_en      (wr_en),
    .i_wr_sel     (i_wr_sel),
    .i_wr_idx     (i_wr_idx),
    .i_wr_data    (i_wr_data),
    .i_step       (bank_step),
    .o_factor_a   (o_factor_a),
    .o_factor_b   (o_factor_b),
    .o_shadow_sum (shadow_sum)
`ifdef COEF_RAMP_EN
    ,
    .o_ramp_last  (ramp_last)
`endif
  );

  // Outputs are registered alongside the state, so each transition sets them explicitly.
  always_ff @(posedge i_clkp or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      flush_cnt     <= '0;
      o_wr_rdy      <= 1'b1;
      o_busy        <= 1'b0;
      o_swap_done   <= 1'b0;
      o_gain_err    <= 1'b0;
      o_filter_rstn <= 1'b1;
      o_swap_cnt    <= '0;
    end else begin
      o_swap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_commit) begin
            state    <= CHECK;
            o_busy   <= 1'b1;
            o_wr_rdy <= 1'b0;
          end
        end
        CHECK: begin
          if (CHECK_UNITY != 0 && shadow_sum != UNITY_SUM) begin
            state      <= IDLE;
            o_gain_err <= 1'b1;
            o_busy     <= 1'b0;
            o_wr_rdy   <= 1'b1;
          end else begin
            state      <= ARMED;
            o_gain_err <= 1'b0;
          end
        end
        ARMED: begin
          if (i_smp_stb) begin
`ifdef COEF_RAMP_EN
            state <= RAMP;
`else
            state <= SWAP;
`endif
          end
        end
        SWAP: begin
          if (FLUSH_CYC > 0) begin
            state         <= FLUSH;
            o_filter_rstn <= 1'b0;
            flush_cnt     <= CNT_W'(FLUSH_CYC - 1);
          end else begin
            state       <= IDLE;
            o_busy      <= 1'b0;
            o_wr_rdy    <= 1'b1;
            o_swap_done <= 1'b1;
            o_swap_cnt  <= o_swap_cnt + 16'd1;
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state         <= IDLE;
            o_filter_rstn <= 1'b1;
            o_busy        <= 1'b0;
            o_wr_rdy      <= 1'b1;
            o_swap_done   <= 1'b1;
            o_swap_cnt    <= o_swap_cnt + 16'd1;
          end else begin
            flush_cnt <= flush_cnt - CNT_W'(1);
          end
        end
`ifdef COEF_RAMP_EN
        RAMP: begin
          // The bank takes its last step on this same strobe.
          if (i_smp_stb && ramp_last) begin
            state       <= IDLE;
            o_busy      <= 1'b0;
            o_wr_rdy    <= 1'b1;
            o_swap_done <= 1'b1;
            o_swap_cnt  <= o_swap_cnt + 16'd1;
          end
        end
`endif
        default: begin
          state         <= IDLE;
          o_busy        <= 1'b0;
          o_wr_rdy      <= 1'b1;
          o_filter_rstn <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_coef_sched.sv
// Directed self-checking bench for iir_coef_sched with default parameters.
// Runs the ramp scenario instead of the swap/flush scenarios when COEF_RAMP_EN is defined.
module tb_iir_coef_sched;

  logic        i_clkp;
  logic        i_rst;
  logic        i_wr_vld;
  logic        o_wr_rdy;
  logic        i_wr_sel;
  logic [1:0]  i_wr_idx;
  logic [15:0] i_wr_data;
  logic        i_commit;
  logic        i_smp_stb;
  logic [63:0] o_factor_a;
  logic [63:0] o_factor_b;
  logic        o_filter_rstn;
  logic        o_busy;
  logic        o_swap_done;
  logic        o_gain_err;
  logic [15:0] o_swap_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] RST_A = 64'h7530;  // a0 = 30000
  localparam logic [63:0] RST_B = 64'h0AD0;  // b0 = 2768

  iir_coef_sched dut (
    .i_clkp        (i_clkp),
    .i_rst         (i_rst),
    .i_wr_vld      (i_wr_vld),
    .o_wr_rdy      (o_wr_rdy),
    .i_wr_sel      (i_wr_sel),
    .i_wr_idx      (i_wr_idx),
    .i_wr_data     (i_wr_data),
    .i_commit      (i_commit),
    .i_smp_stb     (i_smp_stb),
    .o_factor_a    (o_factor_a),
    .o_factor_b    (o_factor_b),
    .o_filter_rstn (o_filter_rstn),
    .o_busy        (o_busy),
    .o_swap_done   (o_swap_done),
    .o_gain_err    (o_gain_err),
    .o_swap_cnt    (o_swap_cnt)
  );

  initial i_clkp = 1'b0;
  always #5 i_clkp = ~i_clkp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clkp);
      #1;
    end
  endtask

  task automatic wr(input logic sel, input logic [1:0] idx, input logic [15:0] data,
                    input logic commit);
    i_wr_vld  = 1'b1;
    i_wr_sel  = sel;
    i_wr_idx  = idx;
    i_wr_data = data;
    i_commit  = commit;
    tick();
    i_wr_vld  = 1'b0;
    i_commit  = 1'b0;
  endtask

  task automatic strobe();
    i_smp_stb = 1'b1;
    tick();
    i_smp_stb = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int low_cnt;
    int done_cnt;
    i_rst     = 1'b1;
    i_wr_vld  = 1'b0;
    i_wr_sel  = 1'b0;
    i_wr_idx  = '0;
    i_wr_data = '0;
    i_commit  = 1'b0;
    i_smp_stb = 1'b0;
    tick(2);
    i_rst = 1'b0;

    check("rst_factor_a", o_factor_a, RST_A);
    check("rst_factor_b", o_factor_b, RST_B);
    check("rst_filter_rstn", o_filter_rstn, 1);
    check("rst_swap_cnt", o_swap_cnt, 0);
    check("rst_wr_rdy", o_wr_rdy, 1);
    check("rst_busy", o_busy, 0);
    check("rst_gain_err", o_gain_err, 0);
    check("rst_swap_done", o_swap_done, 0);

`ifdef COEF_RAMP_EN
    // Ramp: a0 30000 -> 27000, b0 2768 -> 5768 in 1000 steps.
    wr(1'b0, 2'd0, 16'd27000, 1'b0);
    wr(1'b1, 2'd0, 16'd5768, 1'b1);
    tick();
    check("ramp_armed_busy", o_busy, 1);
    strobe();
    check("ramp_enter_a", o_factor_a, RST_A);
    strobe();
    check("ramp1_a", o_factor_a, 64'h7148);
    check("ramp1_b", o_factor_b, 64'h0EB8);
    check("ramp1_done", o_swap_done, 0);
    strobe();
    check("ramp2_a", o_factor_a, 64'h6D60);
    check("ramp2_b", o_factor_b, 64'h12A0);
    check("ramp2_done", o_swap_done, 0);
    check("ramp2_rstn", o_filter_rstn, 1);
    strobe();
    check("ramp3_a", o_factor_a, 64'h6978);
    check("ramp3_b", o_factor_b, 64'h1688);
    check("ramp3_done", o_swap_done, 1);
    check("ramp3_rstn", o_filter_rstn, 1);
    tick();
    check("ramp_busy_end", o_busy, 0);
    check("ramp_swap_cnt", o_swap_cnt, 1);
`else
    // Valid commit: a0 = 20000, b0 = 12768; b0 write shares the cycle with the commit.
    wr(1'b0, 2'd0, 16'd20000, 1'b0);
    wr(1'b1, 2'd0, 16'd12768, 1'b1);
    check("t2_check_busy", o_busy, 1);
    check("t2_check_wr_rdy", o_wr_rdy, 0);
    tick();
    check("t2_armed_gain_err", o_gain_err, 0);
    tick(4);
    check("t2_armed_factor_a", o_factor_a, RST_A);
    strobe();
    check("t2_swap_factor_a_old", o_factor_a, RST_A);
    tick();
    check("t2_factor_a_new", o_factor_a, 64'h4E20);
    check("t2_factor_b_new", o_factor_b, 64'h31E0);
    low_cnt  = 0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_filter_rstn === 1'b0) low_cnt++;
      if (o_swap_done === 1'b1) done_cnt++;
      tick();
    end
    check("t2_flush_low_cycles", low_cnt, 4);
    check("t2_swap_done_pulses", done_cnt, 1);
    check("t2_swap_cnt", o_swap_cnt, 1);
    check("t2_idle_busy", o_busy, 0);
    check("t2_idle_wr_rdy", o_wr_rdy, 1);

    // Rejected commit: shadow becomes a0 = 20000, b0 = 2768 (sum 22768).
    wr(1'b1, 2'd0, 16'd2768, 1'b1);
    check("t3_check_busy", o_busy, 1);
    tick();
    check("t3_gain_err", o_gain_err, 1);
    check("t3_busy_cleared", o_busy, 0);
    check("t3_wr_rdy", o_wr_rdy, 1);
    strobe();
    check("t3_factor_a_kept", o_factor_a, 64'h4E20);
    check("t3_factor_b_kept", o_factor_b, 64'h31E0);
    check("t3_swap_cnt_kept", o_swap_cnt, 1);

    // Valid commit a0 = 10000, a1 = 6384, b0 = 16384; writes and a commit pushed in ARMED.
    wr(1'b0, 2'd0, 16'd10000, 1'b0);
    wr(1'b0, 2'd1, 16'd6384, 1'b0);
    wr(1'b1, 2'd0, 16'd16384, 1'b1);
    tick();
    check("t4_gain_err_cleared", o_gain_err, 0);
    i_wr_vld  = 1'b1;
    i_wr_sel  = 1'b0;
    i_wr_idx  = 2'd3;
    i_wr_data = 16'hFFFF;
    i_commit  = 1'b1;
    tick();
    check("t4_armed_wr_rdy", o_wr_rdy, 0);
    check("t4_armed_busy", o_busy, 1);
    i_commit = 1'b0;
    tick();
    i_wr_vld = 1'b0;
    strobe();
    tick();
    check("t4_factor_a", o_factor_a, 64'h0000_0000_18F0_2710);
    check("t4_factor_b", o_factor_b, 64'h4000);
    tick(4);
    check("t4_swap_done", o_swap_done, 1);
    check("t4_swap_cnt", o_swap_cnt, 2);
    tick(6);
    check("t4_no_queued_commit", o_busy, 0);
    check("t4_swap_cnt_once", o_swap_cnt, 2);

    // Reset during FLUSH: a1 = 0, b0 = 22768 committed, then i_rst between edges.
    wr(1'b0, 2'd1, 16'd0, 1'b0);
    wr(1'b1, 2'd0, 16'd22768, 1'b1);
    tick();
    strobe();
    tick();
    check("t5_flush_rstn", o_filter_rstn, 0);
    check("t5_factor_b", o_factor_b, 64'h58F0);
    tick();
    #2 i_rst = 1'b1;
    #1;
    check("t5_async_rstn", o_filter_rstn, 1);
    check("t5_async_factor_a", o_factor_a, RST_A);
    check("t5_async_factor_b", o_factor_b, RST_B);
    check("t5_async_busy", o_busy, 0);
    check("t5_async_swap_cnt", o_swap_cnt, 0);
    tick();
    i_rst = 1'b0;
    // Committing the untouched shadow bank must reapply the reset coefficients.
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    tick();
    check("t5_shadow_gain_err", o_gain_err, 0);
    strobe();
    tick();
    check("t5_shadow_factor_a", o_factor_a, RST_A);
    check("t5_shadow_factor_b", o_factor_b, RST_B);
    tick(4);
    check("t5_swap_cnt", o_swap_cnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
